// File: rtl/fetch_pkg.sv
// Shared constants and helpers for the fetch address generator.
package fetch_pkg;

  localparam int XLEN       = 32;
  localparam int INST_BYTES = 4;

  localparam logic [XLEN-1:0] PC_RESET = 32'h0000_2000;

  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return {pc[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_perf_ctr.sv
// Free-running 32-bit event counter with synchronous clear and count enable.
module fetch_perf_ctr
  import fetch_pkg::*;
(
  input  logic            clk,
  input  logic            clr,
  input  logic            en,
  output logic [XLEN-1:0] count
);

  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + XLEN'(1);
    end
  end

endmodule

// File: rtl/fetch_pc.sv
// PC / instruction-fetch address generator with stall hold and buffered redirects.
// Optional performance counters are built when FETCH_PERF_EN is defined.
module fetch_pc
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = PC_RESET
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] imem_addr,
  output logic [XLEN-1:0] pc_f,
  output logic            fetch_valid,
  output logic            redirect_misaligned,
  output logic [XLEN-1:0] fetch_count,
  output logic [XLEN-1:0] redirect_count
);

  logic [XLEN-1:0] pc_q;
  logic            valid_q;
  logic            pend_q;
  logic [XLEN-1:0] pend_pc_q;
  logic            misal_q;

  logic [XLEN-1:0] target;
  assign target = align_pc(redirect_pc);

  always_comb begin
    imem_addr = pc_q + XLEN'(INST_BYTES);
    if (!reset_n) begin
      imem_addr = RESET_PC;
    end else if (redirect_valid && !stall) begin
      imem_addr = target;
    end else if (stall) begin
      imem_addr = pc_q;
    end else if (pend_q) begin
      imem_addr = pend_pc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pc_q      <= RESET_PC;
      valid_q   <= 1'b1;
      pend_q    <= 1'b0;
      pend_pc_q <= '0;
      misal_q   <= 1'b0;
    end else begin
      pc_q    <= imem_addr;
      valid_q <= 1'b1;
      misal_q <= redirect_valid && (redirect_pc[1:0] != 2'b00);
      // A stalled redirect is parked; any unstalled cycle retires the parked one.
      if (redirect_valid && stall) begin
        pend_q    <= 1'b1;
        pend_pc_q <= target;
      end else if (!stall) begin
        pend_q <= 1'b0;
      end
    end
  end

  // Outputs are forced to their reset view while reset_n is held low.
  assign pc_f                = reset_n ? pc_q : RESET_PC;
  assign fetch_valid         = reset_n && valid_q;
  assign redirect_misaligned = reset_n && misal_q;

`ifdef FETCH_PERF_EN
  logic fetch_en;
  logic redirect_en;

  assign fetch_en    = reset_n && !stall && fetch_valid;
  assign redirect_en = reset_n && !stall && (redirect_valid || pend_q);

  fetch_perf_ctr u_fetch_ctr (
    .clk   (clk),
    .clr   (!reset_n),
    .en    (fetch_en),
    .count (fetch_count)
  );

  fetch_perf_ctr u_redirect_ctr (
    .clk   (clk),
    .clr   (!reset_n),
    .en    (redirect_en),
    .count (redirect_count)
  );
`else
  assign fetch_count    = '0;
  assign redirect_count = '0;
`endif

endmodule

// File: doc/fetch_pc.md
# fetch_pc

Program-counter and instruction-fetch address generator for the 3-stage pipeline. It drives the synchronous instruction-memory address port (one-cycle read latency). It also tracks the PC of the instruction currently emerging from memory. The memory data output feeds the stall handler downstream, and the fetch stage reads the PC/valid pair in lockstep with that data. The block holds on `stall`, takes redirects from execute, and buffers a redirect that arrives during a stall until the stall releases.

## Interface
- RESET_PC, 32'h0000_2000, first fetch address after reset
- clk  input  1  rising-edge clock
- reset_n  input  1  synchronous, active-low reset
- stall  input  1  pipeline stall; same signal driven to the downstream stall handler
- redirect_valid  input  1  execute-stage branch/jump taken this cycle
- redirect_pc  input  32  redirect target; bits [1:0] ignored
- imem_addr  output  32  address presented to instruction memory this cycle (combinational)
- pc_f  output  32  address whose data is on the memory output this cycle
- fetch_valid  output  1  pc_f/memory data are meaningful
- redirect_misaligned  output  1  one-cycle pulse: accepted redirect had redirect_pc[1:0] != 0
- fetch_count  output  32  fetched-instruction counter (see Configuration)
- redirect_count  output  32  applied-redirect counter (see Configuration)

## Operation
- State: pc_q (32), valid_q, pend_q, pend_pc_q (32), misal_q.
- imem_addr priority, evaluated when reset_n=1:
  - redirect_valid && !stall: {redirect_pc[31:2],2'b00}
  - else if stall: pc_q (hold)
  - else if pend_q: pend_pc_q
  - else: pc_q + 4
- When reset_n=0, imem_addr = RESET_PC.
- pc_q <= imem_addr every cycle, with reset behaviour below.
- Addition is modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000. No error is flagged.
- Pending redirect:
  - redirect_valid && stall: pend_q<=1, pend_pc_q<=aligned target. A later redirect during the same stall overwrites it.
  - Cleared on the first non-stall cycle, whether the pending target is consumed or an unstalled redirect_valid supersedes it.
- redirect_misaligned: asserted the cycle after a redirect is captured (either path) with redirect_pc[1:0] != 0.
- Downstream is responsible for flushing wrong-path instructions; this block only steers the address.

## Timing
- Reset (reset_n=0 at an edge) sets:
  - pc_q=RESET_PC, valid_q=1, pend_q=0, pend_pc_q=0, misal_q=0, counters=0.
- Outputs while reset_n is held low: fetch_valid=0, pc_f=RESET_PC, redirect_misaligned=0.
- First cycle after release:
  - fetch_valid=1, pc_f=RESET_PC, imem_addr=RESET_PC+4.
- Latency: an address issued on imem_addr in cycle N appears as pc_f in cycle N+1, alongside its memory data.
- Stall held k cycles: pc_f and imem_addr are constant for k cycles. The address advances on the first unstalled cycle.
- Redirect without stall in cycle N: imem_addr = target in N, pc_f = target in N+1.
- Redirect during stall: the target is applied to imem_addr in the first cycle stall=0.
- Reset asserted mid-stall or with a redirect pending discards the pending redirect. The reset values above take effect on that edge.

## Configuration
- Macro FETCH_PERF_EN.
- With FETCH_PERF_EN defined:
  - fetch_count increments on every cycle with reset_n=1, stall=0, fetch_valid=1.
  - redirect_count increments on every cycle a redirect is applied to imem_addr (unstalled redirect or consumed pending).
  - Both counters wrap at 2^32 and clear on reset.
- Without it: both ports are present but tied to 32'h0, and no counter flops are synthesized.

## Structure
- Shared package fetch_pkg:
  - XLEN=32
  - INST_BYTES=4
  - PC_RESET default constant 32'h0000_2000, which feeds RESET_PC
- One sub-module, fetch_perf_ctr: a 32-bit enable/clear counter, instantiated twice and only under FETCH_PERF_EN.
- All remaining logic lives in fetch_pc.

## Test plan
- Reset release, no stall: cycle 0 pc_f=0x2000/valid=1, cycle 1 pc_f=0x2004, cycle 2 pc_f=0x2008. imem_addr leads pc_f by one cycle.
- Stall high for 3 cycles starting with pc_f=0x2008: pc_f and imem_addr stay 0x2008 throughout. The cycle after release gives imem_addr=0x200C.
- Unstalled redirect_pc=0x3003 in cycle N: imem_addr=0x3000 in N; pc_f=0x3000 and redirect_misaligned=1 in N+1; pulse clears in N+2.
- Redirect 0x4000 during stall, then 0x5000 in a later stall cycle: imem_addr held until release. The first unstalled cycle gives imem_addr=0x5000, and pend_q clears.
- pc_f=0xFFFF_FFFC unstalled: next pc_f=0x0000_0000.
- With FETCH_PERF_EN: 10 unstalled fetches with 2 redirects give fetch_count=10 and redirect_count=2. A reset mid-stall with a redirect pending gives counters=0 and first pc_f=0x2000.
